// File: rtl/memory_pkg.sv
// Shared types and helpers for the dual-port memory: clear-engine states,
// per-byte merge for the write-to-read bypass, and parameter legality checks.
`timescale 1ns/1ps
package memory_pkg;

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } clear_state_t;

    // Words are handled at a fixed maximum width so one function serves every DATA_W.
    localparam int MAX_W = 512;
    typedef logic [MAX_W-1:0]   word_t;
    typedef logic [MAX_W/8-1:0] be_t;

    function automatic word_t merge_bytes(input word_t old_word,
                                          input word_t new_word,
                                          input be_t   be);
        word_t merged;
        merged = old_word;
        for (int i = 0; i < MAX_W/8; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

    function automatic bit params_legal(input int data_w, input int addr_w,
                                        input int depth, input int rd_lat);
        return (data_w > 0) && (data_w % 8 == 0) && (data_w <= MAX_W) &&
               (rd_lat == 1 || rd_lat == 2) &&
               (addr_w > 0) && (addr_w < 31) &&
               (depth >= 1) && (depth <= (1 << addr_w));
    endfunction

endpackage

// File: rtl/memory_clear_fsm.sv
// Post-reset clear engine: walks the address space writing zeros, then
// hands the write port over to the user.
`timescale 1ns/1ps
module memory_clear_fsm
    import memory_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 512
) (
    input  logic              clk,
    input  logic              rst,
    output logic              init_busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    clear_state_t      state, state_nxt;
    logic [ADDR_W-1:0] ptr, ptr_nxt;
    logic              busy_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_CLEAR;
            ptr       <= '0;
            init_busy <= 1'b1;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            init_busy <= busy_nxt;
        end
    end

    // init_busy drops on the same edge that writes the final zero.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        busy_nxt  = init_busy;
        clr_we    = 1'b0;
        clr_addr  = ptr;
        case (state)
            ST_CLEAR: begin
                clr_we = 1'b1;
                if (ptr == LAST_ADDR) begin
                    state_nxt = ST_READY;
                    busy_nxt  = 1'b0;
                    ptr_nxt   = '0;
                end else begin
                    ptr_nxt = ptr + 1'b1;
                end
            end
            ST_READY: begin
                busy_nxt = 1'b0;
            end
            default: begin
                state_nxt = ST_CLEAR;
                busy_nxt  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/memory_dp.sv
// Simple-dual-port RAM with byte-enabled writes, 1- or 2-cycle reads,
// same-cycle per-byte bypass and a self-clearing array after reset.
`timescale 1ns/1ps
module memory_dp
    import memory_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 512,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    output logic                init_busy,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid
);

    localparam int BE_W = DATA_W / 8;
    localparam logic [ADDR_W:0] ADDR_LIM = (ADDR_W + 1)'(DEPTH);

    if (!params_legal(DATA_W, ADDR_W, DEPTH, RD_LAT)) begin : g_illegal_params
        $error("memory_dp: illegal parameter combination");
    end

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              ready, user_wr_ok, rd_accept, rd_in_range;
    logic              mux_we;
    logic [ADDR_W-1:0] mux_addr;
    logic [DATA_W-1:0] mux_data, rd_word;
    logic [BE_W-1:0]   mux_be;
    word_t             old_x, new_x, merged_x;
    be_t               be_x;
    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;

    memory_clear_fsm #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_clear (
        .clk       (clk),
        .rst       (rst),
        .init_busy (init_busy),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr)
    );

    assign ready       = ~init_busy;
    assign user_wr_ok  = ready && wr_en && ({1'b0, wr_addr} < ADDR_LIM);
    assign rd_accept   = ready && rd_en;
    assign rd_in_range = {1'b0, rd_addr} < ADDR_LIM;

    // Clear-engine writes take priority over the user port.
    always_comb begin
        mux_we   = 1'b0;
        mux_addr = wr_addr;
        mux_data = wr_data;
        mux_be   = wr_be;
        if (clr_we) begin
            mux_we   = 1'b1;
            mux_addr = clr_addr;
            mux_data = '0;
            mux_be   = '1;
        end else if (user_wr_ok) begin
            mux_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mux_we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (mux_be[i]) begin
                    mem[mux_addr][8*i +: 8] <= mux_data[8*i +: 8];
                end
            end
        end
    end

    // Read word with bytes being written this cycle taken from wr_data.
    always_comb begin
        old_x = '0;
        new_x = '0;
        be_x  = '0;
        old_x[DATA_W-1:0] = mem[rd_addr];
        new_x[DATA_W-1:0] = wr_data;
        if (user_wr_ok && (wr_addr == rd_addr)) begin
            be_x[BE_W-1:0] = wr_be;
        end
        merged_x = merge_bytes(old_x, new_x, be_x);
        rd_word  = rd_in_range ? merged_x[DATA_W-1:0] : '0;
    end

    if (DATA_W < MAX_W) begin : g_unused_hi
        logic unused_merge_hi;
        assign unused_merge_hi = ^merged_x[MAX_W-1:DATA_W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_accept;
            s1_data  <= rd_accept ? rd_word : '0;
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic              s2_valid;
        logic [DATA_W-1:0] s2_data;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s2_valid <= 1'b0;
                s2_data  <= '0;
            end else begin
                s2_valid <= s1_valid;
                s2_data  <= s1_data;
            end
        end

        assign rd_valid = s2_valid;
        assign rd_data  = s2_data;
    end else begin : g_lat1
        assign rd_valid = s1_valid;
        assign rd_data  = s1_data;
    end

endmodule

// File: tb/tb_memory_dp.sv
// Bench for memory_dp: a 512-deep 1-cycle instance and a 300-deep 2-cycle
// instance share one stimulus stream, each checked against its own array model.
`timescale 1ns/1ps
module tb_memory_dp;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, rd_en;
    logic [8:0]  wr_addr, rd_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        init_busy1, init_busy2, rd_valid1, rd_valid2;
    logic [31:0] rd_data1, rd_data2;

    memory_dp #(.DATA_W(32), .ADDR_W(9), .DEPTH(512), .RD_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .init_busy(init_busy1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1)
    );

    memory_dp #(.DATA_W(32), .ADDR_W(9), .DEPTH(300), .RD_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .init_busy(init_busy2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data2), .rd_valid(rd_valid2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] data;
    } slot_t;

    typedef struct {
        logic        wr_en;
        logic [8:0]  wr_addr;
        logic [31:0] wr_data;
        logic [3:0]  wr_be;
        logic        rd_en;
        logic [8:0]  rd_addr;
        logic        exp_valid;
        logic [31:0] exp_data;
    } vec_t;

    // Model: plain word arrays, a count of remaining clear cycles, and a
    // queue of read results delayed by the instance's latency.
    logic [31:0] model_mem [2][512];
    int          remaining [2];
    int          depth_of  [2] = '{512, 300};
    slot_t       q1[$];
    slot_t       q2[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cnt1, cnt2;
    vec_t        vecs [9];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic modelReset();
        for (int d = 0; d < 2; d++) begin
            remaining[d] = depth_of[d];
            for (int a = 0; a < 512; a++) model_mem[d][a] = 32'h0;
        end
        q1.delete();
        q2.delete();
        q2.push_back('{1'b0, 32'h0});
    endtask

    task automatic modelStep(input int d, output slot_t s);
        s = '{1'b0, 32'h0};
        if (remaining[d] > 0) begin
            remaining[d]--;
        end else begin
            if (wr_en && int'(wr_addr) < depth_of[d]) begin
                for (int b = 0; b < 4; b++)
                    if (wr_be[b]) model_mem[d][wr_addr][8*b +: 8] = wr_data[8*b +: 8];
            end
            if (rd_en) begin
                s.valid = 1'b1;
                s.data  = (int'(rd_addr) < depth_of[d]) ? model_mem[d][rd_addr] : 32'h0;
            end
        end
    endtask

    // One clock edge with the currently driven inputs, then full compare.
    task automatic applyStimulus();
        slot_t e1, e2;
        modelStep(0, e1);
        modelStep(1, e2);
        q1.push_back(e1);
        q2.push_back(e2);
        @(posedge clk);
        #1;
        e1 = q1.pop_front();
        e2 = q2.pop_front();
        checkOutput("dut1_rd_valid", {31'b0, rd_valid1}, {31'b0, e1.valid});
        checkOutput("dut1_rd_data", rd_data1, e1.data);
        checkOutput("dut1_init_busy", {31'b0, init_busy1}, {31'b0, remaining[0] > 0});
        checkOutput("dut2_rd_valid", {31'b0, rd_valid2}, {31'b0, e2.valid});
        checkOutput("dut2_rd_data", rd_data2, e2.data);
        checkOutput("dut2_init_busy", {31'b0, init_busy2}, {31'b0, remaining[1] > 0});
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_dut1_valid"}, {31'b0, rd_valid1}, 32'h0);
        checkOutput({tag, "_dut1_data"}, rd_data1, 32'h0);
        checkOutput({tag, "_dut1_busy"}, {31'b0, init_busy1}, 32'h1);
        checkOutput({tag, "_dut2_valid"}, {31'b0, rd_valid2}, 32'h0);
        checkOutput({tag, "_dut2_data"}, rd_data2, 32'h0);
        checkOutput({tag, "_dut2_busy"}, {31'b0, init_busy2}, 32'h1);
    endtask

    task automatic randomInputs();
        wr_en   = 1'($urandom_range(0, 1));
        wr_addr = ($urandom_range(0, 1) == 1) ? 9'($urandom_range(0, 15)) : 9'($urandom_range(0, 511));
        wr_data = $urandom;
        wr_be   = 4'($urandom_range(0, 15));
        rd_en   = 1'($urandom_range(0, 1));
        rd_addr = ($urandom_range(0, 1) == 1) ? 9'($urandom_range(0, 15)) : 9'($urandom_range(0, 511));
    endtask

    task automatic idleInputs();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
        rd_en = 1'b0; rd_addr = '0;
    endtask

    task automatic setInputs(input logic we, input logic [8:0] wa, input logic [31:0] wd,
                             input logic [3:0] be, input logic re, input logic [8:0] ra);
        wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be; rd_en = re; rd_addr = ra;
    endtask

    // Counts the edges at which each instance is still clearing.
    task automatic runClear(input string tag);
        cnt1 = 0;
        cnt2 = 0;
        for (int i = 0; i < 1000 && (init_busy1 || init_busy2); i++) begin
            if (init_busy1) cnt1++;
            if (init_busy2) cnt2++;
            randomInputs();
            applyStimulus();
        end
        checkOutput({tag, "_clear_len_dut1"}, cnt1, 32'd512);
        checkOutput({tag, "_clear_len_dut2"}, cnt2, 32'd300);
    endtask

    initial begin
        rst = 1'b1;
        idleInputs();
        repeat (3) @(posedge clk);
        #1;
        checkReset("reset");
        rst = 1'b0;
        modelReset();

        repeat (100) begin
            randomInputs();
            applyStimulus();
        end
        rst = 1'b1;
        #1;
        checkReset("rst_mid_clear");
        modelReset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        runClear("first");

        vecs[0] = '{1'b0, 9'd0, 32'h0,        4'h0, 1'b1, 9'd0,   1'b1, 32'h0};
        vecs[1] = '{1'b0, 9'd0, 32'h0,        4'h0, 1'b1, 9'd255, 1'b1, 32'h0};
        vecs[2] = '{1'b0, 9'd0, 32'h0,        4'h0, 1'b1, 9'd511, 1'b1, 32'h0};
        vecs[3] = '{1'b1, 9'd5, 32'hDEADBEEF, 4'hF, 1'b0, 9'd0,   1'b0, 32'h0};
        vecs[4] = '{1'b1, 9'd5, 32'h11223344, 4'h5, 1'b0, 9'd0,   1'b0, 32'h0};
        vecs[5] = '{1'b0, 9'd0, 32'h0,        4'h0, 1'b1, 9'd5,   1'b1, 32'hDE22BE44};
        vecs[6] = '{1'b1, 9'd7, 32'h12345678, 4'hF, 1'b0, 9'd0,   1'b0, 32'h0};
        vecs[7] = '{1'b1, 9'd7, 32'hA5A5A5A5, 4'h3, 1'b1, 9'd7,   1'b1, 32'h1234A5A5};
        vecs[8] = '{1'b0, 9'd0, 32'h0,        4'h0, 1'b1, 9'd7,   1'b1, 32'h1234A5A5};
        for (int i = 0; i < 9; i++) begin
            setInputs(vecs[i].wr_en, vecs[i].wr_addr, vecs[i].wr_data, vecs[i].wr_be,
                      vecs[i].rd_en, vecs[i].rd_addr);
            applyStimulus();
            checkOutput($sformatf("vec%0d_valid", i), {31'b0, rd_valid1}, {31'b0, vecs[i].exp_valid});
            checkOutput($sformatf("vec%0d_data", i), rd_data1, vecs[i].exp_data);
        end

        // Two-cycle latency with back-to-back reads and a trailing gap.
        setInputs(1'b1, 9'd1, 32'h1, 4'hF, 1'b0, 9'd0); applyStimulus();
        setInputs(1'b1, 9'd2, 32'h2, 4'hF, 1'b0, 9'd0); applyStimulus();
        setInputs(1'b1, 9'd3, 32'h3, 4'hF, 1'b0, 9'd0); applyStimulus();
        setInputs(1'b0, 9'd0, 32'h0, 4'h0, 1'b1, 9'd1); applyStimulus();
        checkOutput("lat2_before", {31'b0, rd_valid2}, 32'h0);
        setInputs(1'b0, 9'd0, 32'h0, 4'h0, 1'b1, 9'd2); applyStimulus();
        checkOutput("lat2_r1_valid", {31'b0, rd_valid2}, 32'h1);
        checkOutput("lat2_r1_data", rd_data2, 32'h1);
        setInputs(1'b0, 9'd0, 32'h0, 4'h0, 1'b1, 9'd3); applyStimulus();
        checkOutput("lat2_r2_valid", {31'b0, rd_valid2}, 32'h1);
        checkOutput("lat2_r2_data", rd_data2, 32'h2);
        idleInputs(); applyStimulus();
        checkOutput("lat2_r3_valid", {31'b0, rd_valid2}, 32'h1);
        checkOutput("lat2_r3_data", rd_data2, 32'h3);
        applyStimulus();
        checkOutput("lat2_gap_valid", {31'b0, rd_valid2}, 32'h0);
        checkOutput("lat2_gap_data", rd_data2, 32'h0);

        // Address 400 lies beyond the 300-word instance but inside the 512-word one.
        setInputs(1'b1, 9'd400, 32'hFFFFFFFF, 4'hF, 1'b1, 9'd400); applyStimulus();
        checkOutput("addr400_dut1_data", rd_data1, 32'hFFFFFFFF);
        idleInputs(); applyStimulus();
        checkOutput("oor_dut2_valid", {31'b0, rd_valid2}, 32'h1);
        checkOutput("oor_dut2_data", rd_data2, 32'h0);

        repeat (1500) begin
            randomInputs();
            applyStimulus();
        end

        // Reset while a read is still in the two-stage pipeline.
        setInputs(1'b0, 9'd0, 32'h0, 4'h0, 1'b1, 9'd5); applyStimulus();
        idleInputs();
        rst = 1'b1;
        #1;
        checkReset("rst_pending_read");
        modelReset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        runClear("second");
        repeat (20) begin
            randomInputs();
            applyStimulus();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
